result_beat_drain: RTL and testbench
====================================

# result_beat_drain

Drains one C tile from the row-banked result BRAMs (bank = row, addr = {bankset_sel, col}) and emits it as P-element packed beats with keep mask and last marker. Supports row-major or column-major order, sustains one BRAM read per cycle under backpressure via a credit-controlled prefetch FIFO, and rejects illegal tile shapes. It sits between the C banks and the output DMA/stream path and replaces the single-element drain-plus-external-packer arrangement.

## Interface
- W, 8, element width in bits
- T, 16, number of banks (max tile rows)
- AW, 10, per-bank address width; column field is AW-1 bits
- P, 4, elements per output beat (≥1)
- FD, 4, prefetch FIFO depth (≥3 for full throughput)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin draining; ignored unless IDLE
- busy  out  1  drain in progress
- done  out  1  1-cycle pulse, tile complete
- err  out  1  1-cycle pulse, start rejected (bad shape)
- tile_rows  in  16  rows, legal 0..T
- tile_cols  in  16  cols, legal 0..2**(AW-1)
- bankset_sel  in  1  address MSB
- col_major  in  1  0 = row-major, 1 = column-major
- a_en  out  T  per-bank read enable
- a_addr  out  T×AW  per-bank read address
- a_dout  in  T×W  per-bank read data, valid 1 cycle after a_en
- out_valid  out  1  beat valid
- out_data  out  P×W  lane k at bits [k*W +: W]
- out_keep  out  P  lane valid mask
- out_last  out  1  final beat of tile
- out_ready  in  1  downstream accept

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, sample tile_rows/cols, bankset_sel, col_major into registers (inputs ignored thereafter).
  - rows>T or cols>2**(AW-1): pulse err next cycle, stay IDLE, no reads, no done.
  - rows==0 or cols==0: go DONE (no reads, no beats).
  - else go ISSUE with r=c=0.
- ISSUE: each cycle with credit (fifo_count + inflight < FD) assert a_en[r]=1, a_addr[r]={bankset_sel, c[AW-2:0]}, all other banks a_en=0, addr 0. Advance: row-major c++ wrapping to 0 with r++; column-major r++ wrapping to 0 with c++. After last element (r=rows-1, c=cols-1) issued go DRAIN.
- Read return: a_dout[bank of the issue one cycle earlier] written into FIFO; inflight tracked so FIFO never overflows.
- Packer: pops FIFO into lane index k (0..P-1), k resets per beat. Beat closes when k=P-1 or element is the tile's last. Closed beat loads output register when empty or being accepted same cycle; otherwise FIFO pop stalls.
- Partial final beat: out_keep = low n bits set (n = remaining elements), unused lanes data 0. Full beats keep all ones. out_last=1 only on final beat.
- DRAIN: no new reads; when final beat handshakes go DONE.
- DONE: done=1 for one cycle, return IDLE.
- busy=1 in ISSUE and DRAIN; 0 in IDLE and DONE.
- Element count rows*cols computed in 32 bits; beats = ceil(count/P).

## Timing
- Reset values: busy 0, done 0, err 0, a_en 0, a_addr 0, out_valid 0, out_data 0, out_keep 0, out_last 0; FIFO empty, state IDLE.
- Reset mid-tile: immediate return to IDLE, in-flight reads discarded, no done.
- start in cycle 0 → first a_en in cycle 1; no stalls → first out_valid in cycle P+3.
- Steady state with out_ready=1: one read per cycle, one beat every P cycles, no bubbles (P=1 → one beat per cycle).
- out_valid && !out_ready: out_data/keep/last held stable; reads continue until credit exhausted, then a_en deasserts; resume within 1 cycle of out_ready returning.
- done asserted the cycle after final beat handshake; empty tile: done in cycle 2 after start in cycle 0.
- start while busy or in DONE: ignored, no err.

## Test plan
- 4×4 row-major, P=4, out_ready=1: 4 beats, beat0 lanes = C[0][0..3], keep=4'b1111, out_last on beat 3, done one cycle later, 16 consecutive a_en cycles.
- 3×5 column-major, P=4: 15 elements order C[0][0],C[1][0],C[2][0],C[0][1]…; 4 beats, last beat keep=4'b0111, lane3 data 0.
- 16×16 with out_ready toggling pseudo-randomly: data/order exact, output stable while stalled, FIFO never exceeds FD, no lost or duplicated element.
- tile_rows=17 → err pulse, no a_en, no done; tile_cols=0 → no beats, done in cycle 2.
- rst asserted mid-drain of 8×8 → all outputs 0 next cycle; subsequent 2×2 tile drains correctly with bankset_sel=1 (addresses 512, 513).
- start pulsed again during busy → ignored; single done, beat count unchanged.

Source files
------------

// File: rtl/result_beat_drain_if.sv
// result_beat_drain_if: packed output beat stream (valid/ready).
// master drives valid/data/keep/last; slave drives ready.
interface result_beat_drain_if #(
    parameter int W = 8,
    parameter int P = 4
);
    logic           valid;
    logic [P*W-1:0] data;
    logic [P-1:0]   keep;
    logic           last;
    logic           ready;

    modport master (
        output valid, data, keep, last,
        input  ready
    );

    modport slave (
        input  valid, data, keep, last,
        output ready
    );
endinterface

// File: rtl/result_beat_drain.sv
// result_beat_drain: drains a C tile from row-banked BRAMs into P-lane beats.
// Ports: start/busy/done/err control, tile shape, per-bank BRAM read, out_if stream.
module result_beat_drain #(
    parameter int W  = 8,
    parameter int T  = 16,
    parameter int AW = 10,
    parameter int P  = 4,
    parameter int FD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic [15:0]         tile_rows_i,
    input  logic [15:0]         tile_cols_i,
    input  logic                bankset_sel_i,
    input  logic                col_major_i,
    output logic [T-1:0]        a_en_o,
    output logic [T*AW-1:0]     a_addr_o,
    input  logic [T*W-1:0]      a_dout_i,
    result_beat_drain_if.master out_if
);
    localparam int CW   = AW - 1;
    localparam int MAXC = 1 << CW;
    localparam int KW   = (P > 1) ? $clog2(P) : 1;
    localparam int FPW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int FCW  = $clog2(FD + 1);
    localparam int BW   = (T > 1) ? $clog2(T) : 1;

    localparam logic [KW-1:0]  KLAST = KW'(P - 1);
    localparam logic [FPW-1:0] PLAST = FPW'(FD - 1);
    localparam logic [FCW:0]   FDV   = FD[FCW:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q;
    logic [15:0]    rows_q;
    logic [15:0]    cols_q;
    logic [15:0]    r_q;
    logic [15:0]    c_q;
    logic           sel_q;
    logic           cm_q;
    logic [31:0]    total_q;
    logic [31:0]    pop_cnt_q;
    logic           rd_pend_q;
    logic [BW-1:0]  rd_bank_q;
    logic [W-1:0]   fifo_q [FD];
    logic [FPW-1:0] wp_q;
    logic [FPW-1:0] rp_q;
    logic [FCW-1:0] cnt_q;
    logic [KW-1:0]  k_q;
    logic [P*W-1:0] pk_q;
    logic           ov_q;
    logic [P*W-1:0] od_q;
    logic [P-1:0]   okeep_q;
    logic           olast_q;
    logic           done_q;
    logic           err_q;
    logic           hold_q;

    logic [FCW:0]   occ;
    logic           credit;
    logic           issue;
    logic           last_issue;
    logic           accept;
    logic           out_free;
    logic           push;
    logic           pop;
    logic           pk_last;
    logic           pk_close;
    logic [W-1:0]   head;
    logic [P*W-1:0] beat_d;
    logic [P-1:0]   keep_d;
    logic           bad_shape;
    logic           empty_shape;

    // Credit counts the read returning next cycle so the FIFO cannot overflow.
    assign occ        = {1'b0, cnt_q} + {{FCW{1'b0}}, rd_pend_q};
    assign credit     = occ < FDV;
    assign issue      = (state_q == ISSUE) && credit;
    assign last_issue = (r_q == rows_q - 16'd1)
                     && (c_q == cols_q - 16'd1);
    assign accept     = ov_q && out_if.ready;
    assign out_free   = !ov_q || out_if.ready;
    assign push       = rd_pend_q;
    assign head       = fifo_q[rp_q];
    assign pk_last    = (pop_cnt_q == total_q - 32'd1);
    assign pk_close   = (k_q == KLAST) || pk_last;
    // Only the pop that closes a beat needs room in the output register.
    assign pop        = (cnt_q != '0) && (!pk_close || out_free);

    assign bad_shape   = (tile_rows_i > 16'(T))
                      || ({1'b0, tile_cols_i} > 17'(MAXC));
    assign empty_shape = (tile_rows_i == 16'd0)
                      || (tile_cols_i == 16'd0);

    assign busy_o       = (state_q == ISSUE) || (state_q == DRAIN);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign out_if.valid = ov_q;
    assign out_if.data  = od_q;
    assign out_if.keep  = okeep_q;
    assign out_if.last  = olast_q;

    always_comb begin
        a_en_o   = '0;
        a_addr_o = '0;
        for (int b = 0; b < T; b++) begin
            if (issue && (r_q == 16'(b))) begin
                a_en_o[b]            = 1'b1;
                a_addr_o[b*AW +: AW] = {sel_q, c_q[CW-1:0]};
            end
        end
    end

    always_comb begin
        beat_d = pk_q;
        keep_d = '0;
        for (int i = 0; i < P; i++) begin
            if (k_q == KW'(i)) begin
                beat_d[i*W +: W] = head;
            end
            keep_d[i] = (KW'(i) <= k_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wp_q] <= a_dout_i[rd_bank_q*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            sel_q     <= 1'b0;
            cm_q      <= 1'b0;
            total_q   <= '0;
            pop_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            rd_bank_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            pk_q      <= '0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            okeep_q   <= '0;
            olast_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= issue;
            rd_bank_q <= r_q[BW-1:0];
            cnt_q     <= cnt_q + FCW'(push) - FCW'(pop);
            if (push) begin
                wp_q <= (wp_q == PLAST) ? '0 : wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= (rp_q == PLAST) ? '0 : rp_q + 1'b1;
            end
            if (accept) begin
                ov_q <= 1'b0;
            end
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + 32'd1;
                if (pk_close) begin
                    ov_q    <= 1'b1;
                    od_q    <= beat_d;
                    okeep_q <= keep_d;
                    olast_q <= pk_last;
                    k_q     <= '0;
                    pk_q    <= '0;
                end else begin
                    pk_q <= beat_d;
                    k_q  <= k_q + 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rows_q    <= tile_rows_i;
                        cols_q    <= tile_cols_i;
                        sel_q     <= bankset_sel_i;
                        cm_q      <= col_major_i;
                        total_q   <= 32'(tile_rows_i) * 32'(tile_cols_i);
                        pop_cnt_q <= '0;
                        r_q       <= '0;
                        c_q       <= '0;
                        k_q       <= '0;
                        pk_q      <= '0;
                        if (bad_shape) begin
                            err_q <= 1'b1;
                        end else if (empty_shape) begin
                            // Empty tile waits one cycle in DONE before done.
                            state_q <= DONE;
                            hold_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end else if (cm_q) begin
                            if (r_q == rows_q - 16'd1) begin
                                r_q <= '0;
                                c_q <= c_q + 16'd1;
                            end else begin
                                r_q <= r_q + 16'd1;
                            end
                        end else begin
                            if (c_q == cols_q - 16'd1) begin
                                c_q <= '0;
                                r_q <= r_q + 16'd1;
                            end else begin
                                c_q <= c_q + 16'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept && olast_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (hold_q) begin
                        hold_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_beat_drain.sv
// tb_result_beat_drain: random-data BRAM model, beat scoreboard from tile order.
// Checks latency, order, keep/last, stall stability, err/empty/reset paths.
module tb_result_beat_drain;
    localparam int W  = 8;
    localparam int T  = 16;
    localparam int AW = 10;
    localparam int P  = 4;
    localparam int FD = 4;
    localparam int BB = P * W + P + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     tile_rows;
    logic [15:0]     tile_cols;
    logic            bankset_sel;
    logic            col_major;
    logic [T-1:0]    a_en;
    logic [T*AW-1:0] a_addr;
    logic [T*W-1:0]  a_dout;

    result_beat_drain_if #(.W(W), .P(P)) oif ();

    result_beat_drain #(
        .W(W), .T(T), .AW(AW), .P(P), .FD(FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .tile_rows_i   (tile_rows),
        .tile_cols_i   (tile_cols),
        .bankset_sel_i (bankset_sel),
        .col_major_i   (col_major),
        .a_en_o        (a_en),
        .a_addr_o      (a_addr),
        .a_dout_i      (a_dout),
        .out_if        (oif)
    );

    logic [W-1:0]  mem [T][1 << AW];
    logic [BB-1:0] exp_q[$];
    int            addr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_ready = 0;
    int start_cyc, first_aen, last_aen, aen_cnt;
    int first_valid, last_hs, beats, acc_elems, max_out;
    int done_cnt, done_cyc, err_cnt, err_cyc;
    bit stall_prev = 0;
    logic [BB-1:0] held;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        for (int b = 0; b < T; b++) begin
            if (a_en[b]) begin
                a_dout[b*W +: W] <= mem[b][a_addr[b*AW +: AW]];
            end
        end
    end

    initial begin
        oif.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            oif.ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic chk(string tag, longint obs, longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            chk("aen_onehot", longint'($onehot0(a_en)), 1);
            if (a_en != '0) begin
                aen_cnt++;
                if (first_aen < 0) first_aen = cyc;
                last_aen = cyc;
                for (int b = 0; b < T; b++) begin
                    if (a_en[b]) begin
                        addr_q.push_back(b * 1024
                            + int'(a_addr[b*AW +: AW]));
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (oif.valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stall_prev) begin
                    chk("stall_stable",
                        longint'({oif.data, oif.keep, oif.last}),
                        longint'(held));
                end
                if (oif.ready) begin
                    chk("beat_expected", longint'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("beat",
                            longint'({oif.data, oif.keep, oif.last}),
                            longint'(exp_q.pop_front()));
                    end
                    beats++;
                    last_hs = cyc;
                    acc_elems += $countones(oif.keep);
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    held = {oif.data, oif.keep, oif.last};
                end
            end else begin
                stall_prev = 0;
            end
            if (aen_cnt - acc_elems > max_out) begin
                max_out = aen_cnt - acc_elems;
            end
        end
    end

    // Reference: list elements in tile order, then cut into P-lane beats.
    task automatic build_exp(int rows, int cols, bit sel, bit cm);
        logic [W-1:0]   el[$];
        logic [P*W-1:0] d;
        logic [P-1:0]   k;
        int             n;
        if (cm) begin
            for (int j = 0; j < cols; j++)
                for (int i = 0; i < rows; i++)
                    el.push_back(mem[i][{sel, 9'(j)}]);
        end else begin
            for (int i = 0; i < rows; i++)
                for (int j = 0; j < cols; j++)
                    el.push_back(mem[i][{sel, 9'(j)}]);
        end
        n = el.size();
        for (int b = 0; b * P < n; b++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < P; l++) begin
                if (b * P + l < n) begin
                    d[l*W +: W] = el[b*P + l];
                    k[l] = 1'b1;
                end
            end
            exp_q.push_back({d, k, 1'(b * P + P >= n)});
        end
    endtask

    task automatic start_tile(int rows, int cols, bit sel, bit cm);
        @(posedge clk);
        #1;
        tile_rows   = 16'(rows);
        tile_cols   = 16'(cols);
        bankset_sel = sel;
        col_major   = cm;
        start       = 1'b1;
        start_cyc   = cyc;
        first_aen   = -1;
        last_aen    = -1;
        aen_cnt     = 0;
        first_valid = -1;
        last_hs     = -1;
        beats       = 0;
        acc_elems   = 0;
        max_out     = 0;
        done_cnt    = 0;
        done_cyc    = -1;
        err_cnt     = 0;
        err_cyc     = -1;
        exp_q.delete();
        addr_q.delete();
        if (rows <= T && cols <= 512) build_exp(rows, cols, sel, cm);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", longint'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        #1;
        chk("done_single", done_cnt, 1);
        chk("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int r;
        int c;
        int n;
        for (int b = 0; b < T; b++)
            for (int a = 0; a < (1 << AW); a++)
                mem[b][a] = W'($urandom);
        rst = 1'b1;
        start = 1'b0;
        tile_rows = '0;
        tile_cols = '0;
        bankset_sel = 1'b0;
        col_major = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", longint'({busy, done, err, oif.valid,
            oif.last, oif.keep}), 0);
        chk("rst_aen", longint'(a_en), 0);
        chk("rst_data", longint'(oif.data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4 row-major, continuous ready
        start_tile(4, 4, 0, 0);
        wait_done(200);
        chk("first_aen", first_aen, start_cyc + 1);
        chk("aen_cnt", aen_cnt, 16);
        chk("aen_contig", last_aen - first_aen, 15);
        chk("first_valid", first_valid, start_cyc + P + 3);
        chk("beats_4x4", beats, 4);
        chk("beat_rate", last_hs, first_valid + 3 * P);
        chk("done_lat", done_cyc, last_hs + 1);
        chk("idle_busy", longint'(busy), 0);

        // 3x5 column-major, partial last beat
        start_tile(3, 5, 0, 1);
        wait_done(200);
        chk("beats_3x5", beats, 4);
        chk("aen_3x5", aen_cnt, 15);

        // 16x16 under random backpressure
        rnd_ready = 1;
        start_tile(16, 16, 1'($urandom % 2), 1'($urandom % 2));
        wait_done(5000);
        chk("beats_16x16", beats, 64);
        chk("outstanding", longint'(max_out <= FD + 2 * P - 1), 1);

        // random shapes and orders
        for (int t = 0; t < 3; t++) begin
            r = $urandom_range(1, 16);
            c = $urandom_range(1, 40);
            n = r * c;
            start_tile(r, c, 1'($urandom % 2), 1'($urandom % 2));
            wait_done(5000);
            chk("beats_rnd", beats, (n + P - 1) / P);
            chk("outstanding_rnd",
                longint'(max_out <= FD + 2 * P - 1), 1);
        end
        rnd_ready = 0;

        // illegal shape
        start_tile(17, 4, 0, 0);
        repeat (8) @(negedge clk);
        #1;
        chk("err_cnt", err_cnt, 1);
        chk("err_lat", err_cyc, start_cyc + 1);
        chk("err_no_aen", aen_cnt, 0);
        chk("err_no_done", done_cnt, 0);

        // empty tile
        start_tile(3, 0, 0, 0);
        wait_done(20);
        chk("empty_done_lat", done_cyc, start_cyc + 2);
        chk("empty_no_aen", aen_cnt, 0);
        chk("empty_no_beat", beats, 0);

        // reset in the middle of an 8x8 drain
        rnd_ready = 1;
        start_tile(8, 8, 0, 0);
        n = 0;
        while (beats < 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_beats", longint'(beats >= 3), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_outs", longint'({busy, done, err, oif.valid,
            oif.last, oif.keep}), 0);
        chk("mrst_aen", longint'(a_en), 0);
        chk("mrst_addr", longint'(a_addr == '0), 1);
        chk("mrst_data", longint'(oif.data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rnd_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("mrst_no_done", done_cnt, 0);

        start_tile(2, 2, 1, 0);
        wait_done(200);
        chk("addr_n", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
            chk("addr0", addr_q[0], 512);
            chk("addr1", addr_q[1], 513);
            chk("addr2", addr_q[2], 1024 + 512);
            chk("addr3", addr_q[3], 1024 + 513);
        end
        chk("beats_2x2", beats, 1);

        // start pulsed while busy
        start_tile(4, 4, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tile_rows = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        chk("rstart_beats", beats, 4);
        chk("rstart_err", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
